// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing: PC/IF/ID/ID-EX enables, flush and bubble control,
// plus the ID/EX hazard-vector register and a saturating stall counter.
module pipeline_stall_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [10:0]      haz_in,
    input  logic             stall_in,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic [10:0]      fwd_ex,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] LDUSE  = 2'd1;
    localparam logic [1:0] MDBUSY = 2'd2;
    localparam logic [1:0] HALTED = 2'd3;

    localparam logic [3:0] MD_INIT = 4'(MD_LAT - 1);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] md_cnt_q;
    logic [3:0] md_cnt_d;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_bubble = 1'b0;
        state_d     = state_q;
        md_cnt_d    = md_cnt_q;
        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (md_start) begin
                    state_d  = MDBUSY;
                    md_cnt_d = MD_INIT;
                end else if (stall_in) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = LDUSE;
                end else if (halt) begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = HALTED;
                end
            end
            LDUSE: begin
                // stall_in is masked here so each load-use costs one bubble
                state_d = RUN;
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
            end
            MDBUSY: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                md_cnt_d = md_cnt_q - 4'd1;
                if (md_cnt_q <= 4'd1) begin
                    state_d = RUN;
                end
            end
            HALTED: begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                idex_en = 1'b0;
            end
        endcase
    end

    assign halted = (state_q == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_ex <= 11'd0;
        end else if (idex_en) begin
            fwd_ex <= idex_bubble ? 11'd0 : haz_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!pc_en && !halted && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: comb controls checked per
// cycle, expected fwd_ex queued at drive time and popped after the edge.
module tb_pipeline_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] haz_in = '0;
    logic        stall_in = 1'b0;
    logic        branch_taken = 1'b0;
    logic        md_start = 1'b0;
    logic        halt = 1'b0;

    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, halted;
    logic [10:0] fwd_ex;
    logic [15:0] stall_cnt;

    logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_bubble;
    logic        s_halted;
    logic [10:0] s_fwd_ex;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    pipeline_stall_ctrl dut (
        .clk(clk), .rst_n(rst_n), .haz_in(haz_in), .stall_in(stall_in),
        .branch_taken(branch_taken), .md_start(md_start), .halt(halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_bubble(idex_bubble), .fwd_ex(fwd_ex),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    pipeline_stall_ctrl #(.MD_LAT(4), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .haz_in(haz_in), .stall_in(stall_in),
        .branch_taken(branch_taken), .md_start(md_start), .halt(halt),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
        .idex_en(s_idex_en), .idex_bubble(s_idex_bubble),
        .fwd_ex(s_fwd_ex), .halted(s_halted), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same phase.
    task automatic step(input logic br, input logic md, input logic st,
                        input logic hl, input logic [10:0] haz,
                        input logic [4:0] exp_ctl, input logic [10:0] exp_fwd);
        logic [10:0] e;
        branch_taken = br;
        md_start     = md;
        stall_in     = st;
        halt         = hl;
        haz_in       = haz;
        #1;
        chk("ctl", 32'({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble}),
            32'(exp_ctl));
        exp_q.push_back(exp_fwd);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("fwd_ex", 32'(fwd_ex), 32'(e));
        end
    endtask

    task automatic idle_inputs();
        branch_taken = 1'b0;
        md_start     = 1'b0;
        stall_in     = 1'b0;
        halt         = 1'b0;
        haz_in       = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_fwd", 32'(fwd_ex), 32'd0);
        chk("rst_ctl",
            32'({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble}),
            32'b11010);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    localparam logic [4:0] NORM  = 5'b11010;
    localparam logic [4:0] STALL = 5'b00011;
    localparam logic [4:0] FLUSH = 5'b11111;
    localparam logic [4:0] FROZE = 5'b00000;

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // idle, then 1-cycle fwd_ex latency
        step(0, 0, 0, 0, 11'h000, NORM, 11'h000);
        step(0, 0, 0, 0, 11'h0A5, NORM, 11'h0A5);
        chk("idle_cnt", 32'(stall_cnt), 32'd0);
        chk("idle_halted", 32'(halted), 32'd0);

        // load-use: one bubble, stall masked in LDUSE
        do_reset();
        step(0, 0, 1, 0, 11'h404, STALL, 11'h000);
        step(0, 0, 1, 0, 11'h404, NORM, 11'h404);
        step(0, 0, 0, 0, 11'h000, NORM, 11'h000);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);

        // mult/div: 3 frozen cycles with fwd_ex held
        do_reset();
        step(0, 1, 0, 0, 11'h123, NORM, 11'h123);
        for (int i = 0; i < 3; i++)
            step(1, 0, 1, 1, 11'h3FF, FROZE, 11'h123);
        step(0, 0, 0, 0, 11'h7FF, NORM, 11'h7FF);
        chk("md_cnt", 32'(stall_cnt), 32'd3);

        // branch beats everything else
        do_reset();
        step(0, 0, 0, 0, 11'h155, NORM, 11'h155);
        step(1, 1, 1, 1, 11'h155, FLUSH, 11'h000);
        step(0, 0, 0, 0, 11'h2AA, NORM, 11'h2AA);
        chk("br_cnt", 32'(stall_cnt), 32'd0);
        chk("br_halted", 32'(halted), 32'd0);

        // halt, then async reset mid-halt
        do_reset();
        step(0, 0, 0, 0, 11'h321, NORM, 11'h321);
        step(0, 0, 0, 1, 11'h321, STALL, 11'h000);
        chk("halt_on", 32'(halted), 32'd1);
        chk("halt_cnt", 32'(stall_cnt), 32'd1);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 11'h7FF, FROZE, 11'h000);
        chk("halt_hold", 32'(halted), 32'd1);
        chk("halt_frozen", 32'(stall_cnt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_halted", 32'(halted), 32'd0);
        chk("async_ctl",
            32'({pc_en, ifid_en, idex_en}), 32'b111);
        @(posedge clk);
        #1;
        do_reset();

        // reset during MDBUSY resumes in RUN
        step(0, 1, 0, 0, 11'h0F0, NORM, 11'h0F0);
        step(0, 0, 0, 0, 11'h000, FROZE, 11'h0F0);
        do_reset();
        step(0, 0, 0, 0, 11'h00F, NORM, 11'h00F);
        chk("md_rst_cnt", 32'(stall_cnt), 32'd0);

        // 20 load-use events: 4-bit counter saturates
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 1, 0, 11'h404, STALL, 11'h000);
            step(0, 0, 0, 0, 11'h404, NORM, 11'h404);
            if (i == 14) chk("sat_15", 32'(s_stall_cnt), 32'd15);
            if (i == 15) chk("sat_hold", 32'(s_stall_cnt), 32'd15);
        end
        chk("sat_small", 32'(s_stall_cnt), 32'd15);
        chk("sat_wide", 32'(stall_cnt), 32'd20);
        chk("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected done");
        $fatal(1);
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
# pipeline_stall_ctrl

Pipeline sequencing block directly downstream of `control_hazard_unit`. It takes the per-cycle hazard vector and load-use stall request, plus branch, mult/div and halt events. From these it drives the pipeline-register enables, flush and bubble controls. It also registers the hazard vector into the ID/EX boundary so the EX-stage forwarding muxes see controls aligned with their instruction.

## Interface
Parameters:
- `MD_LAT`, default 4: cycles a MULT/DIV occupies EX. Legal range is 2..16.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `haz_in` input 11: hazard vector from `control_hazard_unit` for the instruction in ID.
- `stall_in` input 1: load-use stall request from `control_hazard_unit`.
- `branch_taken` input 1: branch resolved taken in EX this cycle.
- `md_start` input 1: the instruction in ID is MULT/DIV and enters EX next edge.
- `halt` input 1: HALT decoded in ID.
- `pc_en` output 1: PC write enable.
- `ifid_en` output 1: IF/ID register write enable.
- `ifid_flush` output 1: clear IF/ID to NOP.
- `idex_en` output 1: ID/EX register write enable.
- `idex_bubble` output 1: load a NOP into ID/EX instead of the ID instruction.
- `fwd_ex` output 11: registered hazard/forward controls for the instruction in EX.
- `halted` output 1: processor halted.
- `stall_cnt` output CNT_W: saturating count of stalled cycles.

## Operation
- State machine with states RUN, LDUSE, MDBUSY and HALTED. A down-counter `md_cnt` of 4 bits is used in MDBUSY.
- Combinational outputs derive from the current state and current inputs.

RUN evaluates events in priority order (highest first):
1. `branch_taken`: `pc_en`=1, `ifid_en`=1, `ifid_flush`=1, `idex_en`=1, `idex_bubble`=1. Stay in RUN. `md_start`, `stall_in` and `halt` are ignored because the ID instruction is flushed.
2. `md_start`: normal advance (all enables 1, no bubble). Go to MDBUSY with `md_cnt`=MD_LAT-1.
3. `stall_in`: `pc_en`=0, `ifid_en`=0, `idex_en`=1, `idex_bubble`=1. Go to LDUSE.
4. `halt`: `pc_en`=0, `ifid_en`=0, `idex_en`=1, `idex_bubble`=1. Go to HALTED.
5. Otherwise: `pc_en`=`ifid_en`=`idex_en`=1, `ifid_flush`=`idex_bubble`=0.

Other states:
- LDUSE: normal advance. `stall_in` is masked, which guarantees exactly one bubble per load-use. `branch_taken` is handled as in RUN. Always return to RUN.
- MDBUSY: `pc_en`=`ifid_en`=`idex_en`=0, no flush or bubble. Decrement `md_cnt`. When `md_cnt`==1, go to RUN next edge. Ignore `branch_taken`, `stall_in` and `halt`; inputs are re-evaluated in RUN.
- HALTED: all enables 0, `halted`=1. Leave only via `rst_n`.

`fwd_ex` register:
- On each edge with `idex_en`=1, load 0 if `idex_bubble` is 1, else `haz_in`.
- Hold when `idex_en`=0.

`stall_cnt`:
- Increment on each edge where `pc_en`=0 and state is not HALTED.
- Saturate at all-ones; no wrap.

## Timing
- Reset (async assert): state RUN, `md_cnt`=0, `fwd_ex`=0, `stall_cnt`=0, `halted`=0.
- With idle inputs during reset: `pc_en`=`ifid_en`=`idex_en`=1, `ifid_flush`=`idex_bubble`=0.
- Reset deasserted mid-MDBUSY or HALTED: the block resumes in RUN with counters cleared. No partial state is retained.
- Enables, flush and bubble have zero latency: they are combinational in the same cycle as the triggering input.
- `fwd_ex` has 1-cycle latency from `haz_in`.
- Load-use costs exactly 1 stall cycle. A taken branch costs 2 flushed slots: IF/ID is flushed and ID/EX is bubbled in the same cycle.
- MULT/DIV stalls the front end for MD_LAT-1 cycles after the issue edge.
- `stall_cnt` updates 1 edge after the stalled cycle.

## Test plan
- Reset then idle, no events: all enables 1, `fwd_ex`=0, `stall_cnt`=0, `halted`=0.
- `haz_in`=11'h404 with `stall_in`=1 for 2 cycles: first cycle `pc_en`=0 and `idex_bubble`=1. Second cycle (LDUSE) advances normally with stall masked. The next `fwd_ex` is 0, then 11'h404. `stall_cnt`=1.
- `md_start` pulse with MD_LAT=4: exactly 3 consecutive cycles with `pc_en`=`ifid_en`=`idex_en`=0. `fwd_ex` is held. `stall_cnt`=3.
- `branch_taken`, `md_start`, `stall_in` and `halt` all asserted in RUN: `ifid_flush`=`idex_bubble`=1, state stays RUN, `fwd_ex` becomes 0 next edge.
- `halt`=1: `halted`=1 next edge, all enables 0 indefinitely, `stall_cnt` frozen. Asserting `rst_n`=0 mid-halt clears everything asynchronously.
- CNT_W=4 with 20 load-use events: `stall_cnt` saturates at 4'hF and never wraps.
